// File: rtl/cc_goalwriter.sv
// cc_goalwriter: goal-row bookkeeping for the frog game.
// Tracks which goal slots are filled, pulses accept/reject per arrival,
// and runs an end-of-level sequence (optional blink, then a levelup pulse).
// Optional feature macro: CC_GOALWRITER_BLINK_EN enables the BLINK
// celebration state; without it a full row goes straight to DONE.
module cc_goalwriter #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int BLINK_TICKS      = 4
) (
  input  logic                        CC_GOALWRITER_CLOCK_50,
  input  logic                        CC_GOALWRITER_RESET_InHigh,
  input  logic                        CC_GOALWRITER_arrive_InLow,
  input  logic [2:0]                  CC_GOALWRITER_column_InBus,
  input  logic                        CC_GOALWRITER_tick_InHigh,
  input  logic                        CC_GOALWRITER_clear_InLow,
  output logic [NUMBER_DATAWIDTH-1:0] CC_GOALWRITER_BACKGMATRIX_data7_OutBus,
  output logic                        CC_GOALWRITER_accept_OutHigh,
  output logic                        CC_GOALWRITER_reject_OutHigh,
  output logic [3:0]                  CC_GOALWRITER_count_OutBus,
  output logic                        CC_GOALWRITER_busy_OutHigh,
  output logic                        CC_GOALWRITER_levelup_OutHigh
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    BLINK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      state, nxt_state;
  logic [NUMBER_DATAWIDTH-1:0] row, nxt_row;
  logic [NUMBER_DATAWIDTH-1:0] nxt_bus;
  logic [NUMBER_DATAWIDTH-1:0] slot;
  logic [3:0]                  count, nxt_count;
  logic                        arrive_q;
  logic                        arrival;
  logic                        col_valid;
  logic                        row_full;
  logic                        nxt_accept, nxt_reject, nxt_levelup;

`ifdef CC_GOALWRITER_BLINK_EN
  localparam int TW = (BLINK_TICKS < 1) ? 1 : $clog2(BLINK_TICKS + 1);
  logic          phase, nxt_phase;
  logic [TW-1:0] tick_cnt, nxt_tick_cnt;
`else
  localparam int UNUSED_BLINK_TICKS = BLINK_TICKS;
  logic unused_tick;
  assign unused_tick = CC_GOALWRITER_tick_InHigh;
`endif

  // A falling edge on the active-low arrive line is one arrival; holding it low counts once.
  assign arrival   = !CC_GOALWRITER_arrive_InLow && arrive_q;
  assign col_valid = int'(CC_GOALWRITER_column_InBus) < NUMBER_DATAWIDTH;
  assign slot      = NUMBER_DATAWIDTH'(1) << CC_GOALWRITER_column_InBus;
  assign row_full  = &row;

  // Next-state and next-output computation; clear overrides every state and any arrival.
  always_comb begin
    nxt_state   = state;
    nxt_row     = row;
    nxt_count   = count;
    nxt_accept  = 1'b0;
    nxt_reject  = 1'b0;
    nxt_levelup = 1'b0;
`ifdef CC_GOALWRITER_BLINK_EN
    nxt_phase    = phase;
    nxt_tick_cnt = tick_cnt;
`endif
    if (!CC_GOALWRITER_clear_InLow) begin
      nxt_state = FILL;
      nxt_row   = '0;
      nxt_count = 4'd0;
`ifdef CC_GOALWRITER_BLINK_EN
      nxt_phase    = 1'b1;
      nxt_tick_cnt = '0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (row_full) begin
`ifdef CC_GOALWRITER_BLINK_EN
            nxt_state    = BLINK;
            nxt_phase    = 1'b1;
            nxt_tick_cnt = '0;
`else
            nxt_state   = DONE;
            nxt_levelup = 1'b1;
`endif
          end else if (arrival && col_valid) begin
            if ((row & slot) != '0) begin
              nxt_reject = 1'b1;
            end else begin
              nxt_row    = row | slot;
              nxt_count  = count + 4'd1;
              nxt_accept = 1'b1;
            end
          end
        end
`ifdef CC_GOALWRITER_BLINK_EN
        BLINK: begin
          if (CC_GOALWRITER_tick_InHigh) begin
            nxt_phase    = !phase;
            nxt_tick_cnt = tick_cnt + TW'(1);
            if (tick_cnt == TW'(BLINK_TICKS - 1)) begin
              nxt_state   = DONE;
              nxt_levelup = 1'b1;
            end
          end
        end
`endif
        DONE: begin
          nxt_state = FILL;
          nxt_row   = '0;
          nxt_count = 4'd0;
`ifdef CC_GOALWRITER_BLINK_EN
          nxt_phase    = 1'b1;
          nxt_tick_cnt = '0;
`endif
        end
        default: begin
          nxt_state = FILL;
        end
      endcase
    end
`ifdef CC_GOALWRITER_BLINK_EN
    nxt_bus = nxt_phase ? nxt_row : '0;
`else
    nxt_bus = nxt_row;
`endif
  end

  // State and all outputs are registered together so every output is glitch-free.
  always_ff @(posedge CC_GOALWRITER_CLOCK_50 or posedge CC_GOALWRITER_RESET_InHigh) begin
    if (CC_GOALWRITER_RESET_InHigh) begin
      state                                  <= FILL;
      row                                    <= '0;
      count                                  <= 4'd0;
      arrive_q                               <= 1'b1;
      CC_GOALWRITER_BACKGMATRIX_data7_OutBus <= '0;
      CC_GOALWRITER_accept_OutHigh           <= 1'b0;
      CC_GOALWRITER_reject_OutHigh           <= 1'b0;
      CC_GOALWRITER_count_OutBus             <= 4'd0;
      CC_GOALWRITER_busy_OutHigh             <= 1'b0;
      CC_GOALWRITER_levelup_OutHigh          <= 1'b0;
`ifdef CC_GOALWRITER_BLINK_EN
      phase                                  <= 1'b1;
      tick_cnt                               <= '0;
`endif
    end else begin
      state                                  <= nxt_state;
      row                                    <= nxt_row;
      count                                  <= nxt_count;
      arrive_q                               <= CC_GOALWRITER_arrive_InLow;
      CC_GOALWRITER_BACKGMATRIX_data7_OutBus <= nxt_bus;
      CC_GOALWRITER_accept_OutHigh           <= nxt_accept;
      CC_GOALWRITER_reject_OutHigh           <= nxt_reject;
      CC_GOALWRITER_count_OutBus             <= nxt_count;
      CC_GOALWRITER_busy_OutHigh             <= (nxt_state != FILL);
      CC_GOALWRITER_levelup_OutHigh          <= nxt_levelup;
`ifdef CC_GOALWRITER_BLINK_EN
      phase                                  <= nxt_phase;
      tick_cnt                               <= nxt_tick_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_cc_goalwriter.sv
// tb_cc_goalwriter: directed self-checking bench for cc_goalwriter.
// Honours CC_GOALWRITER_BLINK_EN to select the expected end-of-level sequence.
module tb_cc_goalwriter;

  logic       clk;
  logic       rst;
  logic       arrive_n;
  logic [2:0] column;
  logic       tick;
  logic       clear_n;
  logic [7:0] bus;
  logic       accept;
  logic       reject;
  logic [3:0] count;
  logic       busy;
  logic       levelup;

  int checks = 0;
  int errors = 0;
  int accept_seen;

  cc_goalwriter #(
    .NUMBER_DATAWIDTH(8),
    .BLINK_TICKS(4)
  ) dut (
    .CC_GOALWRITER_CLOCK_50(clk),
    .CC_GOALWRITER_RESET_InHigh(rst),
    .CC_GOALWRITER_arrive_InLow(arrive_n),
    .CC_GOALWRITER_column_InBus(column),
    .CC_GOALWRITER_tick_InHigh(tick),
    .CC_GOALWRITER_clear_InLow(clear_n),
    .CC_GOALWRITER_BACKGMATRIX_data7_OutBus(bus),
    .CC_GOALWRITER_accept_OutHigh(accept),
    .CC_GOALWRITER_reject_OutHigh(reject),
    .CC_GOALWRITER_count_OutBus(count),
    .CC_GOALWRITER_busy_OutHigh(busy),
    .CC_GOALWRITER_levelup_OutHigh(levelup)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and sample 1 ns later.
  task automatic apply_step();
    @(posedge clk);
    #1;
  endtask

  // Fill all eight slots in order, each as a separate press/release.
  task automatic fill_row();
    for (int c = 0; c < 8; c++) begin
      column   = 3'(c);
      arrive_n = 1'b0;
      apply_step();
      check_output($sformatf("fill_accept_%0d", c), 32'(accept), 32'd1);
      check_output($sformatf("fill_count_%0d", c), 32'(count), 32'(c + 1));
      arrive_n = 1'b1;
      apply_step();
    end
  endtask

  // Single linear sequence of directed steps.
  initial begin
    rst      = 1'b1;
    arrive_n = 1'b1;
    column   = 3'd0;
    tick     = 1'b0;
    clear_n  = 1'b1;
    #2;
    check_output("reset_bus", 32'(bus), 32'h00);
    check_output("reset_count", 32'(count), 32'd0);
    check_output("reset_accept", 32'(accept), 32'd0);
    check_output("reset_reject", 32'(reject), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_levelup", 32'(levelup), 32'd0);
    #10;
    rst = 1'b0;
    apply_step();

    // First arrival at column 3.
    column   = 3'd3;
    arrive_n = 1'b0;
    apply_step();
    check_output("first_accept", 32'(accept), 32'd1);
    check_output("first_bus", 32'(bus), 32'h08);
    check_output("first_count", 32'(count), 32'd1);
    arrive_n = 1'b1;
    apply_step();
    check_output("first_accept_drop", 32'(accept), 32'd0);

    // Second arrival on the same slot is rejected.
    arrive_n = 1'b0;
    apply_step();
    check_output("dup_reject", 32'(reject), 32'd1);
    check_output("dup_accept", 32'(accept), 32'd0);
    check_output("dup_bus", 32'(bus), 32'h08);
    check_output("dup_count", 32'(count), 32'd1);
    arrive_n = 1'b1;
    apply_step();
    check_output("dup_reject_drop", 32'(reject), 32'd0);

    // Restart clears the row.
    clear_n = 1'b0;
    apply_step();
    clear_n = 1'b1;
    check_output("clear_bus", 32'(bus), 32'h00);
    check_output("clear_count", 32'(count), 32'd0);

    // Arrive held low for 20 cycles counts once.
    column      = 3'd5;
    arrive_n    = 1'b0;
    accept_seen = 0;
    for (int i = 0; i < 20; i++) begin
      apply_step();
      if (accept === 1'b1) accept_seen++;
    end
    check_output("held_accepts", 32'(accept_seen), 32'd1);
    check_output("held_bus", 32'(bus), 32'h20);
    check_output("held_count", 32'(count), 32'd1);
    arrive_n = 1'b1;
    apply_step();

    // Fill the whole row from a cleared state.
    clear_n = 1'b0;
    apply_step();
    clear_n = 1'b1;
    fill_row();
    check_output("full_bus", 32'(bus), 32'hFF);
    check_output("full_busy", 32'(busy), 32'd1);
`ifdef CC_GOALWRITER_BLINK_EN
    check_output("blink_no_levelup", 32'(levelup), 32'd0);
    tick = 1'b1; apply_step(); tick = 1'b0;
    check_output("blink_t1_bus", 32'(bus), 32'h00);
    apply_step();
    check_output("blink_idle_bus", 32'(bus), 32'h00);
    tick = 1'b1; apply_step(); tick = 1'b0;
    check_output("blink_t2_bus", 32'(bus), 32'hFF);
    tick = 1'b1; apply_step(); tick = 1'b0;
    check_output("blink_t3_bus", 32'(bus), 32'h00);
    check_output("blink_t3_levelup", 32'(levelup), 32'd0);
    tick = 1'b1; apply_step(); tick = 1'b0;
    check_output("blink_t4_bus", 32'(bus), 32'hFF);
`endif
    check_output("done_levelup", 32'(levelup), 32'd1);
    check_output("done_busy", 32'(busy), 32'd1);
    // An arrival during DONE must be ignored.
    column   = 3'd0;
    arrive_n = 1'b0;
    apply_step();
    check_output("post_levelup", 32'(levelup), 32'd0);
    check_output("post_accept", 32'(accept), 32'd0);
    check_output("post_bus", 32'(bus), 32'h00);
    check_output("post_count", 32'(count), 32'd0);
    check_output("post_busy", 32'(busy), 32'd0);
    apply_step();
    check_output("post_hold_accept", 32'(accept), 32'd0);
    check_output("post_hold_count", 32'(count), 32'd0);
    arrive_n = 1'b1;
    apply_step();

`ifdef CC_GOALWRITER_BLINK_EN
    // Clear mid-BLINK beats a simultaneous arrival and the pending levelup.
    fill_row();
    tick = 1'b1; apply_step(); tick = 1'b0;
    tick = 1'b1; apply_step(); tick = 1'b0;
    check_output("abort_pre_bus", 32'(bus), 32'hFF);
    column   = 3'd2;
    clear_n  = 1'b0;
    arrive_n = 1'b0;
    apply_step();
    clear_n = 1'b1;
    check_output("abort_bus", 32'(bus), 32'h00);
    check_output("abort_accept", 32'(accept), 32'd0);
    check_output("abort_levelup", 32'(levelup), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_count", 32'(count), 32'd0);
    arrive_n = 1'b1;
    apply_step();

    // Asynchronous reset mid-BLINK.
    fill_row();
    tick = 1'b1; apply_step(); tick = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("rst_blink_busy", 32'(busy), 32'd0);
    check_output("rst_blink_bus", 32'(bus), 32'h00);
    check_output("rst_blink_levelup", 32'(levelup), 32'd0);
    #3;
    rst = 1'b0;
    apply_step();
`else
    // Ticks have no effect on the row when blinking is not built in.
    column   = 3'd6;
    arrive_n = 1'b0;
    apply_step();
    arrive_n = 1'b1;
    tick     = 1'b1;
    apply_step();
    tick = 1'b0;
    apply_step();
    check_output("tick_ignored_bus", 32'(bus), 32'h40);
    check_output("tick_ignored_busy", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
